// File: rtl/uart_txrx_param.sv
// Full-duplex UART. The TX bit timer restarts at each frame start. RX uses a free-running
// oversampling baud counter that is re-phased to within one rx_tick of the start edge.
module uart_txrx_param #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_0      = 27,
    parameter int DIV_1      = 14,
    parameter int DIV_2      = 7,
    parameter int DIV_3      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           baud_sel,
    input  logic [1:0]           parity_mode,
    input  logic                 loopback,
    input  logic [DATA_BITS-1:0] tx_byte,
    input  logic                 tx_enable,
    output logic                 TX_BUSSY,
    output logic                 TX_VALID,
    output logic                 tx_out,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    output logic                 rx_error,
    output logic                 rx_bussy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] OS_MID    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    function automatic logic [15:0] div_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return 16'(DIV_0);
            2'd1:    return 16'(DIV_1);
            2'd2:    return 16'(DIV_2);
            default: return 16'(DIV_3);
        endcase
    endfunction

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    tx_state_t            tx_state;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_par_en, tx_par_bit, tx_line, tx_stop_idx, tx_bit_end;
    logic [15:0]          tx_div, tx_div_cnt;
    logic [TW-1:0]        tx_tick_cnt;
    logic [BW-1:0]        tx_bit_idx;

    assign tx_bit_end = (tx_div_cnt == tx_div - 16'd1) && (tx_tick_cnt == OS_LAST);
    assign tx_out     = tx_line | loopback;

    // Handshake: a request is taken on any edge where tx_enable=1 and TX_BUSSY=0,
    // including the cycle TX_VALID pulses; requests while TX_BUSSY=1 are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx_line     <= 1'b1;
            TX_BUSSY    <= 1'b0;
            TX_VALID    <= 1'b0;
            tx_shreg    <= '0;
            tx_par_en   <= 1'b0;
            tx_par_bit  <= 1'b0;
            tx_div      <= div_of(2'd0);
            tx_div_cnt  <= '0;
            tx_tick_cnt <= '0;
            tx_bit_idx  <= '0;
            tx_stop_idx <= 1'b0;
        end else begin
            TX_VALID <= 1'b0;
            if (tx_state != TX_IDLE) begin
                if (tx_div_cnt == tx_div - 16'd1) begin
                    tx_div_cnt  <= '0;
                    tx_tick_cnt <= (tx_tick_cnt == OS_LAST) ? '0 : tx_tick_cnt + 1'b1;
                end else begin
                    tx_div_cnt <= tx_div_cnt + 16'd1;
                end
            end
            case (tx_state)
                TX_IDLE: if (tx_enable) begin
                    tx_state    <= TX_START;
                    tx_line     <= 1'b0;
                    TX_BUSSY    <= 1'b1;
                    tx_shreg    <= tx_byte;
                    tx_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    tx_par_bit  <= (^tx_byte) ^ parity_mode[1];
                    tx_div      <= div_of(baud_sel);
                    tx_div_cnt  <= '0;
                    tx_tick_cnt <= '0;
                end
                TX_START: if (tx_bit_end) begin
                    tx_state   <= TX_DATA;
                    tx_line    <= tx_shreg[0];
                    tx_bit_idx <= '0;
                end
                TX_DATA: if (tx_bit_end) begin
                    if (tx_bit_idx == BIT_LAST) begin
                        tx_state    <= tx_par_en ? TX_PARITY : TX_STOP;
                        tx_line     <= tx_par_en ? tx_par_bit : 1'b1;
                        tx_stop_idx <= 1'b0;
                    end else begin
                        tx_shreg   <= tx_shreg >> 1;
                        tx_line    <= tx_shreg[1];
                        tx_bit_idx <= tx_bit_idx + 1'b1;
                    end
                end
                TX_PARITY: if (tx_bit_end) begin
                    tx_state <= TX_STOP;
                    tx_line  <= 1'b1;
                end
                TX_STOP: if (tx_bit_end) begin
                    if (tx_stop_idx == STOP_LAST) begin
                        tx_state <= TX_IDLE;
                        TX_BUSSY <= 1'b0;
                        TX_VALID <= 1'b1;
                    end else begin
                        tx_stop_idx <= 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    rx_state_t            rx_state;
    logic                 rx_src, rx_s1, rx_s2, rx_s3, rx_fall, rx_tick, rx_sample;
    logic                 rx_par_en, rx_odd, rx_bad, rx_stop_idx;
    logic [15:0]          rx_div, rx_div_cnt;
    logic [TW-1:0]        rx_tick_cnt;
    logic [BW-1:0]        rx_bit_idx;
    logic [DATA_BITS-1:0] rx_shreg;

    assign rx_src    = loopback ? tx_line : rx_in;
    assign rx_fall   = rx_s3 & ~rx_s2;
    assign rx_tick   = rx_div_cnt >= rx_div - 16'd1;
    assign rx_sample = rx_tick && (rx_tick_cnt == ((rx_state == RX_START) ? OS_MID : OS_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_s3       <= 1'b1;
            rx_state    <= RX_IDLE;
            rx_div      <= div_of(2'd0);
            rx_div_cnt  <= '0;
            rx_tick_cnt <= '0;
            rx_bit_idx  <= '0;
            rx_shreg    <= '0;
            rx_par_en   <= 1'b0;
            rx_odd      <= 1'b0;
            rx_bad      <= 1'b0;
            rx_stop_idx <= 1'b0;
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            rx_error    <= 1'b0;
            rx_bussy    <= 1'b0;
        end else begin
            rx_s1      <= rx_src;
            rx_s2      <= rx_s1;
            rx_s3      <= rx_s2;
            rx_valid   <= 1'b0;
            rx_error   <= 1'b0;
            rx_div_cnt <= rx_tick ? '0 : rx_div_cnt + 16'd1;
            if (rx_state == RX_IDLE)
                rx_div <= div_of(baud_sel);
            else if (rx_tick)
                rx_tick_cnt <= rx_sample ? '0 : rx_tick_cnt + 1'b1;
            case (rx_state)
                // Edge-triggered arming: a line stuck low after a bad stop bit never restarts a frame.
                RX_IDLE: if (rx_fall) begin
                    rx_state    <= RX_START;
                    rx_bussy    <= 1'b1;
                    rx_tick_cnt <= '0;
                    rx_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    rx_odd      <= parity_mode[1];
                    rx_bad      <= 1'b0;
                    rx_stop_idx <= 1'b0;
                end
                RX_START: if (rx_sample) begin
                    if (rx_s2) begin
                        rx_state <= RX_IDLE;
                        rx_bussy <= 1'b0;
                    end else begin
                        rx_state   <= RX_DATA;
                        rx_bit_idx <= '0;
                    end
                end
                RX_DATA: if (rx_sample) begin
                    rx_shreg   <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
                    rx_bit_idx <= rx_bit_idx + 1'b1;
                    if (rx_bit_idx == BIT_LAST)
                        rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                end
                RX_PARITY: if (rx_sample) begin
                    rx_bad   <= ((^rx_shreg) ^ rx_s2) != rx_odd;
                    rx_state <= RX_STOP;
                end
                RX_STOP: if (rx_sample) begin
                    if (rx_stop_idx == STOP_LAST) begin
                        rx_byte  <= rx_shreg;
                        rx_error <= rx_bad | ~rx_s2;
                        rx_valid <= ~(rx_bad | ~rx_s2);
                        rx_bussy <= 1'b0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_bad      <= rx_bad | ~rx_s2;
                        rx_stop_idx <= 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_txrx_param.sv
// Directed bench for uart_txrx_param at 32 clk per bit (baud_sel=3, DIV_3=2, OVERSAMPLE=16).
module tb_uart_txrx_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] baud_sel = 2'd3;
    logic [1:0] parity_mode = 2'b00;
    logic       loopback = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_enable = 1'b0;
    logic       TX_BUSSY, TX_VALID, tx_out;
    logic       rx_in = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_error, rx_bussy;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rxv_cnt = 0, rxe_cnt = 0, txv_cnt = 0;
    int tx_rise_cyc = 0, tx_valid_cyc = 0;
    bit busy_prev = 1'b0;
    bit rx_busy_seen = 1'b0;

    uart_txrx_param #(
        .DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16),
        .DIV_0(27), .DIV_1(14), .DIV_2(7), .DIV_3(2)
    ) dut (
        .clk(clk), .rst(rst), .baud_sel(baud_sel), .parity_mode(parity_mode),
        .loopback(loopback), .tx_byte(tx_byte), .tx_enable(tx_enable),
        .TX_BUSSY(TX_BUSSY), .TX_VALID(TX_VALID), .tx_out(tx_out), .rx_in(rx_in),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_error(rx_error), .rx_bussy(rx_bussy)
    );

    // ---------------- clock / event monitor ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) rxv_cnt++;
        if (rx_error) rxe_cnt++;
        if (rx_bussy) rx_busy_seen = 1'b1;
        if (TX_VALID) begin
            txv_cnt++;
            tx_valid_cyc = cyc;
        end
        if (TX_BUSSY && !busy_prev) tx_rise_cyc = cyc;
        busy_prev = TX_BUSSY;
    end

    // ---------------- driver tasks ----------------
    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_byte   = d;
        tx_enable = 1'b1;
        @(negedge clk);
        tx_enable = 1'b0;
    endtask

    task automatic drive_bits(input logic b, input int n);
        rx_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] d, input bit use_par, input logic par, input logic stop);
        @(negedge clk);
        drive_bits(1'b0, 32);
        for (int i = 0; i < 8; i++) drive_bits(d[i], 32);
        if (use_par) drive_bits(par, 32);
        drive_bits(stop, 32);
    endtask

    // ---------------- scenarios ----------------
    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if (tx_out !== 1'b1) begin tests_failed++; $display("FAIL %s_tx_out: got %b expected 1", tag, tx_out); end
        tests_run++;
        if (TX_BUSSY !== 1'b0) begin tests_failed++; $display("FAIL %s_tx_bussy: got %b expected 0", tag, TX_BUSSY); end
        tests_run++;
        if (TX_VALID !== 1'b0) begin tests_failed++; $display("FAIL %s_tx_valid: got %b expected 0", tag, TX_VALID); end
        tests_run++;
        if (rx_byte !== 8'h00) begin tests_failed++; $display("FAIL %s_rx_byte: got %h expected 00", tag, rx_byte); end
        tests_run++;
        if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_rx_valid: got %b expected 0", tag, rx_valid); end
        tests_run++;
        if (rx_error !== 1'b0) begin tests_failed++; $display("FAIL %s_rx_error: got %b expected 0", tag, rx_error); end
        tests_run++;
        if (rx_bussy !== 1'b0) begin tests_failed++; $display("FAIL %s_rx_bussy: got %b expected 0", tag, rx_bussy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_loopback_a5();
        logic [9:0] exp_line;
        int rxv0, rxe0, txv0, waited;
        exp_line = {1'b1, 8'hA5, 1'b0};
        loopback = 1'b1;
        parity_mode = 2'b00;
        repeat (4) @(negedge clk);
        rxv0 = rxv_cnt; rxe0 = rxe_cnt; txv0 = txv_cnt;
        start_tx(8'hA5);
        tests_run++;
        if (TX_BUSSY !== 1'b1) begin tests_failed++; $display("FAIL lb_busy_rise: got %b expected 1", TX_BUSSY); end
        repeat (15) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            tests_run++;
            if (dut.tx_line !== exp_line[k]) begin
                tests_failed++; $display("FAIL lb_line_bit%0d: got %b expected %b", k, dut.tx_line, exp_line[k]);
            end
            tests_run++;
            if (tx_out !== 1'b1) begin tests_failed++; $display("FAIL lb_pin_bit%0d: got %b expected 1", k, tx_out); end
            repeat (32) @(negedge clk);
        end
        waited = 0;
        while (txv_cnt == txv0 && waited < 400) begin @(negedge clk); waited++; end
        tests_run++;
        if (txv_cnt - txv0 !== 1) begin tests_failed++; $display("FAIL lb_tx_valid_count: got %0d expected 1", txv_cnt - txv0); end
        tests_run++;
        if (tx_valid_cyc - tx_rise_cyc !== 320) begin
            tests_failed++; $display("FAIL lb_frame_len: got %0d expected 320", tx_valid_cyc - tx_rise_cyc);
        end
        tests_run++;
        if (rxv_cnt - rxv0 !== 1) begin tests_failed++; $display("FAIL lb_rx_valid_count: got %0d expected 1", rxv_cnt - rxv0); end
        tests_run++;
        if (rxe_cnt - rxe0 !== 0) begin tests_failed++; $display("FAIL lb_rx_error_count: got %0d expected 0", rxe_cnt - rxe0); end
        tests_run++;
        if (rx_byte !== 8'hA5) begin tests_failed++; $display("FAIL lb_rx_byte: got %h expected a5", rx_byte); end
        loopback = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_parity_echo(input logic [1:0] pmode, input logic exp_par, input string tag);
        int rxv0, rxe0, txv0;
        loopback = 1'b0;
        parity_mode = pmode;
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rxv0 = rxv_cnt; rxe0 = rxe_cnt; txv0 = txv_cnt;
        start_tx(8'h07);
        for (int i = 0; i < 400; i++) begin
            if (i == 15 + 32 * 9) begin
                tests_run++;
                if (tx_out !== exp_par) begin tests_failed++; $display("FAIL %s_parity_bit: got %b expected %b", tag, tx_out, exp_par); end
            end
            rx_in = tx_out;
            @(negedge clk);
        end
        rx_in = 1'b1;
        tests_run++;
        if (txv_cnt - txv0 !== 1) begin tests_failed++; $display("FAIL %s_tx_valid_count: got %0d expected 1", tag, txv_cnt - txv0); end
        tests_run++;
        if (tx_valid_cyc - tx_rise_cyc !== 352) begin
            tests_failed++; $display("FAIL %s_frame_len: got %0d expected 352", tag, tx_valid_cyc - tx_rise_cyc);
        end
        tests_run++;
        if (rxv_cnt - rxv0 !== 1) begin tests_failed++; $display("FAIL %s_rx_valid_count: got %0d expected 1", tag, rxv_cnt - rxv0); end
        tests_run++;
        if (rxe_cnt - rxe0 !== 0) begin tests_failed++; $display("FAIL %s_rx_error_count: got %0d expected 0", tag, rxe_cnt - rxe0); end
        tests_run++;
        if (rx_byte !== 8'h07) begin tests_failed++; $display("FAIL %s_rx_byte: got %h expected 07", tag, rx_byte); end
    endtask

    task automatic test_framing_error();
        int rxv0, rxe0;
        parity_mode = 2'b00;
        rxv0 = rxv_cnt; rxe0 = rxe_cnt;
        drive_frame(8'h96, 1'b0, 1'b0, 1'b0);
        drive_bits(1'b0, 200);
        tests_run++;
        if (rxe_cnt - rxe0 !== 1) begin tests_failed++; $display("FAIL frm_error_count: got %0d expected 1", rxe_cnt - rxe0); end
        tests_run++;
        if (rxv_cnt - rxv0 !== 0) begin tests_failed++; $display("FAIL frm_valid_count: got %0d expected 0", rxv_cnt - rxv0); end
        tests_run++;
        if (rx_bussy !== 1'b0) begin tests_failed++; $display("FAIL frm_rearm_low: got %b expected 0", rx_bussy); end
        tests_run++;
        if (rx_byte !== 8'h96) begin tests_failed++; $display("FAIL frm_rx_byte: got %h expected 96", rx_byte); end
        drive_bits(1'b1, 64);
        drive_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        tests_run++;
        if (rxv_cnt - rxv0 !== 1) begin tests_failed++; $display("FAIL frm_next_valid: got %0d expected 1", rxv_cnt - rxv0); end
        tests_run++;
        if (rxe_cnt - rxe0 !== 1) begin tests_failed++; $display("FAIL frm_next_error: got %0d expected 1", rxe_cnt - rxe0); end
        tests_run++;
        if (rx_byte !== 8'h3C) begin tests_failed++; $display("FAIL frm_next_byte: got %h expected 3c", rx_byte); end
    endtask

    task automatic test_false_start();
        int rxv0, rxe0;
        rx_in = 1'b1;
        @(negedge clk);
        rxv0 = rxv_cnt; rxe0 = rxe_cnt;
        rx_busy_seen = 1'b0;
        drive_bits(1'b0, 6);
        drive_bits(1'b1, 60);
        tests_run++;
        if (rx_busy_seen !== 1'b1) begin tests_failed++; $display("FAIL fs_busy_pulse: got %b expected 1", rx_busy_seen); end
        tests_run++;
        if (rx_bussy !== 1'b0) begin tests_failed++; $display("FAIL fs_busy_end: got %b expected 0", rx_bussy); end
        tests_run++;
        if ((rxv_cnt - rxv0) + (rxe_cnt - rxe0) !== 0) begin
            tests_failed++; $display("FAIL fs_no_pulse: got %0d pulses expected 0", (rxv_cnt - rxv0) + (rxe_cnt - rxe0));
        end
        drive_frame(8'h55, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        tests_run++;
        if (rxv_cnt - rxv0 !== 1) begin tests_failed++; $display("FAIL fs_next_valid: got %0d expected 1", rxv_cnt - rxv0); end
        tests_run++;
        if (rx_byte !== 8'h55) begin tests_failed++; $display("FAIL fs_next_byte: got %h expected 55", rx_byte); end
    endtask

    task automatic test_parity_error();
        int rxv0, rxe0;
        parity_mode = 2'b01;
        rxv0 = rxv_cnt; rxe0 = rxe_cnt;
        drive_frame(8'h07, 1'b1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        tests_run++;
        if (rxe_cnt - rxe0 !== 1) begin tests_failed++; $display("FAIL par_error_count: got %0d expected 1", rxe_cnt - rxe0); end
        tests_run++;
        if (rxv_cnt - rxv0 !== 0) begin tests_failed++; $display("FAIL par_valid_count: got %0d expected 0", rxv_cnt - rxv0); end
        tests_run++;
        if (rx_byte !== 8'h07) begin tests_failed++; $display("FAIL par_rx_byte: got %h expected 07", rx_byte); end
        parity_mode = 2'b00;
    endtask

    task automatic test_back_to_back_ignore();
        int rxv0, txv0, waited;
        loopback = 1'b1;
        parity_mode = 2'b00;
        repeat (4) @(negedge clk);
        rxv0 = rxv_cnt; txv0 = txv_cnt;
        start_tx(8'h22);
        repeat (50) @(negedge clk);
        tx_byte = 8'h11;
        tx_enable = 1'b1;
        @(negedge clk);
        tx_enable = 1'b0;
        waited = 0;
        while (txv_cnt == txv0 && waited < 400) begin @(negedge clk); waited++; end
        repeat (400) @(negedge clk);
        tests_run++;
        if (txv_cnt - txv0 !== 1) begin tests_failed++; $display("FAIL ign_tx_valid_count: got %0d expected 1", txv_cnt - txv0); end
        tests_run++;
        if (rxv_cnt - rxv0 !== 1) begin tests_failed++; $display("FAIL ign_rx_valid_count: got %0d expected 1", rxv_cnt - rxv0); end
        tests_run++;
        if (rx_byte !== 8'h22) begin tests_failed++; $display("FAIL ign_rx_byte: got %h expected 22", rx_byte); end
        tests_run++;
        if (TX_BUSSY !== 1'b0) begin tests_failed++; $display("FAIL ign_idle: got %b expected 0", TX_BUSSY); end
    endtask

    task automatic test_reset_mid_frame();
        int rxv0, rxe0, txv0;
        loopback = 1'b1;
        rxv0 = rxv_cnt; rxe0 = rxe_cnt; txv0 = txv_cnt;
        start_tx(8'h5A);
        repeat (100) @(negedge clk);
        tests_run++;
        if (TX_BUSSY !== 1'b1) begin tests_failed++; $display("FAIL rstm_busy_before: got %b expected 1", TX_BUSSY); end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rstm");
        rst = 1'b0;
        repeat (400) @(negedge clk);
        tests_run++;
        if (txv_cnt - txv0 !== 0) begin tests_failed++; $display("FAIL rstm_tx_valid: got %0d expected 0", txv_cnt - txv0); end
        tests_run++;
        if ((rxv_cnt - rxv0) + (rxe_cnt - rxe0) !== 0) begin
            tests_failed++; $display("FAIL rstm_rx_pulses: got %0d expected 0", (rxv_cnt - rxv0) + (rxe_cnt - rxe0));
        end
        loopback = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loopback_a5();
        test_parity_echo(2'b01, 1'b1, "even");
        test_parity_echo(2'b10, 1'b0, "odd");
        test_framing_error();
        test_false_start();
        test_parity_error();
        test_back_to_back_ignore();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
